// File: rtl/i2c_mem_pkg.sv
// Shared types and constants for the I2C memory slave front-end.
package i2c_mem_pkg;

  localparam int BYTE_BITS = 8;
  localparam int BANK_W    = 4;
  localparam int BLOCK_W   = 4;
  localparam int ROW_W     = 8;
  localparam int ADDR_W    = BANK_W + BLOCK_W + ROW_W;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV_ADDR, ST_DEV_ACK, ST_ADDR_HI, ST_ADDR_HI_ACK, ST_ADDR_LO,
    ST_ADDR_LO_ACK, ST_WR_DATA, ST_WR_STROBE, ST_WR_ACK, ST_RD_FETCH, ST_RD_DATA,
    ST_RD_MACK
  } state_e;

  // {bank,block,row} behaves as one counter that wraps at the top of the array.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + 16'd1;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronisers for SCL/SDA and single-cycle bus event pulses.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [1:0] synchroniser stages, [2] previous synced value for edge detection
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // Idle bus is high, so reset to 1 to avoid spurious edges after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_mem_slave_ctrl.sv
// I2C slave front-end that turns bus transactions into memoryBank strobes
// and a self-incrementing {bank,block,row} address.
module i2c_mem_slave_ctrl
  import i2c_mem_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         WR_PULSE = 2,
  parameter int         RD_WAIT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclIn,
  input  logic               sdaIn,
  output logic               sdaOe,
  output logic               memReadN,
  output logic               memWriteN,
  output logic [BANK_W-1:0]  addrBank,
  output logic [BLOCK_W-1:0] addrBlock,
  output logic [ROW_W-1:0]   addrRow,
  output logic [7:0]         memDataOut,
  input  logic [7:0]         memDataIn,
  output logic               busy
);

  localparam logic [2:0] LAST_BIT = 3'(BYTE_BITS - 1);
  localparam logic [3:0] WR_LAST  = 4'(WR_PULSE - 1);
  localparam logic [3:0] RD_LAST  = 4'(RD_WAIT - 1);

  logic sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (sclIn),
    .sda_i     (sdaIn),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise_s),
    .scl_fall_o(scl_fall_s),
    .start_o   (start_s),
    .stop_o    (stop_s)
  );

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_out_q, data_out_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic                oe_q, oe_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic                busy_q, busy_d, rw_q, rw_d;
  logic [7:0]          rx_byte_s;

  assign rx_byte_s = {shift_q[6:0], sda_s};

  // Next-state and output logic; bus START/STOP override every state.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    wait_cnt_d = wait_cnt_q;
    oe_d       = oe_q;
    rd_n_d     = rd_n_q;
    wr_n_d     = wr_n_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    if (start_s || stop_s) begin
      state_d   = start_s ? ST_DEV_ADDR : ST_IDLE;
      busy_d    = start_s ? busy_q : 1'b0;
      bit_cnt_d = 3'd0;
      oe_d      = 1'b0;
      rd_n_d    = 1'b1;
      wr_n_d    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: bit_cnt_d = 3'd0;
        ST_DEV_ADDR, ST_ADDR_HI, ST_ADDR_LO, ST_WR_DATA: begin
          if (scl_rise_s) begin
            shift_d   = rx_byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
              case (state_q)
                ST_DEV_ADDR: begin
                  if (rx_byte_s[7:1] == DEV_ADDR) begin
                    state_d = ST_DEV_ACK;
                    busy_d  = 1'b1;
                    rw_d    = rx_byte_s[0];
                  end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                  end
                end
                ST_ADDR_HI: begin
                  addr_d[15:8] = rx_byte_s;
                  state_d      = ST_ADDR_HI_ACK;
                end
                ST_ADDR_LO: begin
                  addr_d[7:0] = rx_byte_s;
                  state_d     = ST_ADDR_LO_ACK;
                end
                default: begin
                  data_out_d = rx_byte_s;
                  wr_n_d     = 1'b0;
                  wait_cnt_d = 4'd0;
                  state_d    = ST_WR_STROBE;
                end
              endcase
            end
          end
        end
        // First SCL fall drives ACK, second releases it and moves on.
        ST_DEV_ACK, ST_ADDR_HI_ACK, ST_ADDR_LO_ACK, ST_WR_ACK: begin
          if (scl_fall_s) begin
            oe_d = ~oe_q;
            if (oe_q) begin
              bit_cnt_d = 3'd0;
              case (state_q)
                ST_DEV_ACK:     state_d = ST_ADDR_HI;
                ST_ADDR_HI_ACK: state_d = ST_ADDR_LO;
                default:        state_d = ST_WR_DATA;
              endcase
            end
          end else if (scl_rise_s && oe_q && state_q == ST_DEV_ACK && rw_q) begin
            // Fetch while the master samples ACK so bit 7 is ready at the next fall.
            state_d    = ST_RD_FETCH;
            rd_n_d     = 1'b0;
            wait_cnt_d = 4'd0;
          end else begin
            state_d = state_q;
          end
        end
        ST_WR_STROBE: begin
          if (wait_cnt_q == WR_LAST) begin
            wr_n_d  = 1'b1;
            addr_d  = addr_inc(addr_q);
            state_d = ST_WR_ACK;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
        ST_RD_FETCH: begin
          if (wait_cnt_q == RD_LAST) begin
            shift_d   = memDataIn;
            rd_n_d    = 1'b1;
            addr_d    = addr_inc(addr_q);
            bit_cnt_d = 3'd0;
            state_d   = ST_RD_DATA;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
        ST_RD_DATA: begin
          if (scl_fall_s) begin
            oe_d = ~shift_q[7];
          end else if (scl_rise_s) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = (bit_cnt_q == LAST_BIT) ? ST_RD_MACK : ST_RD_DATA;
          end else begin
            state_d = state_q;
          end
        end
        ST_RD_MACK: begin
          if (scl_fall_s) begin
            oe_d = 1'b0;
          end else if (scl_rise_s) begin
            if (sda_s == ACK) begin
              state_d    = ST_RD_FETCH;
              rd_n_d     = 1'b0;
              wait_cnt_d = 4'd0;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      addr_q     <= 16'd0;
      data_out_q <= 8'd0;
      wait_cnt_q <= 4'd0;
      oe_q       <= 1'b0;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      wait_cnt_q <= wait_cnt_d;
      oe_q       <= oe_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end

  assign sdaOe      = oe_q;
  assign memReadN   = rd_n_q;
  assign memWriteN  = wr_n_q;
  assign addrBank   = addr_q[15:12];
  assign addrBlock  = addr_q[11:8];
  assign addrRow    = addr_q[7:0];
  assign memDataOut = data_out_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_mem_slave_ctrl.sv
// Bench: bit-banged I2C master, memoryBank model, and strobe scoreboard.
module tb_i2c_mem_slave_ctrl;

  localparam int Q = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sdaOe, memReadN, memWriteN, busy;
  logic [3:0] addrBank, addrBlock;
  logic [7:0] addrRow, memDataOut, memDataIn;
  logic [7:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          width;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [15:0] rd_q[$];

  assign sda_bus   = sda_m & ~sdaOe;
  assign memDataIn = mem[{addrBank, addrBlock, addrRow}];

  always #5 clk = ~clk;

  i2c_mem_slave_ctrl dut (
    .clk(clk), .reset(reset), .sclIn(scl), .sdaIn(sda_bus), .sdaOe(sdaOe),
    .memReadN(memReadN), .memWriteN(memWriteN), .addrBank(addrBank),
    .addrBlock(addrBlock), .addrRow(addrRow), .memDataOut(memDataOut),
    .memDataIn(memDataIn), .busy(busy)
  );

  always @(posedge clk)
    if (memWriteN === 1'b0) mem[{addrBank, addrBlock, addrRow}] <= memDataOut;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write-strobe scoreboard
  initial forever begin
    wr_exp_t e;
    int w;
    @(negedge memWriteN);
    #1;
    if (wr_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL wr_unexpected: write at %0h data %0h, none expected",
               {addrBank, addrBlock, addrRow}, memDataOut);
    end else begin
      e = wr_q.pop_front();
      chk("wr_addr", {16'd0, addrBank, addrBlock, addrRow}, {16'd0, e.addr});
      chk("wr_data", {24'd0, memDataOut}, {24'd0, e.data});
      w = 1;
      while (memWriteN === 1'b0 && w < 64) begin
        @(posedge clk); #1;
        if (memWriteN === 1'b0) w++;
      end
      if (e.width != 0) chk("wr_width", w, e.width);
    end
  end

  // Read-strobe scoreboard
  initial forever begin
    logic [15:0] a;
    @(negedge memReadN);
    #1;
    if (rd_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL rd_unexpected: read at %0h, none expected", {addrBank, addrBlock, addrRow});
    end else begin
      a = rd_q.pop_front();
      chk("rd_addr", {16'd0, addrBank, addrBlock, addrRow}, {16'd0, a});
    end
  end

  always @(memReadN or memWriteN)
    if (reset === 1'b0 && memReadN === 1'b0 && memWriteN === 1'b0) begin
      errors++;
      $display("FAIL strobe_overlap: memReadN=0 memWriteN=0 together");
    end

  always @(sdaOe)
    if (reset === 1'b0) chk("sdaoe_scl_low", {31'd0, scl}, 32'd0);

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic i2c_start();
    sda_m = 1'b1; #(Q); scl = 1'b1; #(Q); sda_m = 1'b0; #(Q); scl = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #(Q); scl = 1'b1; #(Q); sda_m = 1'b1; #(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #(Q); scl = 1'b1; #(2*Q); scl = 1'b0; #(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #(Q); scl = 1'b1; #(Q); b = sda_bus; #(Q); scl = 1'b0; #(Q);
  endtask

  task automatic write_byte(input string name, input logic [7:0] d, input logic exp_ack);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    chk(name, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic read_byte(input string name, input logic [7:0] exp, input logic mack);
    logic [7:0] r;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      r[i] = b;
    end
    write_bit(mack);
    chk(name, {24'd0, r}, {24'd0, exp});
  endtask

  function automatic wr_exp_t mk_wr(input logic [15:0] a, input logic [7:0] d, input int w);
    wr_exp_t e;
    e.addr = a; e.data = d; e.width = w;
    return e;
  endfunction

  initial begin
    logic [7:0] d77;
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hA1;
    mem[16'h1235] = 8'hB2;
    mem[16'h1236] = 8'hC3;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_sdaoe", {31'd0, sdaOe}, 32'd0);
    chk("rst_rdn", {31'd0, memReadN}, 32'd1);
    chk("rst_wrn", {31'd0, memWriteN}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", {16'd0, addrBank, addrBlock, addrRow}, 32'd0);
    chk("rst_dout", {24'd0, memDataOut}, 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // 1: byte write C5 at 3A10
    wr_q.push_back(mk_wr(16'h3A10, 8'hC5, 2));
    i2c_start();
    write_byte("t1_dev_ack", 8'hA0, 1'b0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    write_byte("t1_hi_ack", 8'h3A, 1'b0);
    write_byte("t1_lo_ack", 8'h10, 1'b0);
    write_byte("t1_data_ack", 8'hC5, 1'b0);
    i2c_stop();
    #(Q);
    chk("t1_busy_off", {31'd0, busy}, 32'd0);
    chk("t1_addr_next", {16'd0, addrBank, addrBlock, addrRow}, 32'h3A11);

    // 2: random read of 3A10
    rd_q.push_back(16'h3A10);
    i2c_start();
    write_byte("t2_dev_ack", 8'hA0, 1'b0);
    write_byte("t2_hi_ack", 8'h3A, 1'b0);
    write_byte("t2_lo_ack", 8'h10, 1'b0);
    i2c_start();
    write_byte("t2_devr_ack", 8'hA1, 1'b0);
    read_byte("t2_data", 8'hC5, 1'b1);
    chk("t2_idle_busy", {31'd0, busy}, 32'd0);
    chk("t2_sda_rel", {31'd0, sdaOe}, 32'd0);
    i2c_stop();

    // 3: wrong device address, then a matching START
    i2c_start();
    write_byte("t3_nack", 8'hA2, 1'b1);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    i2c_start();
    write_byte("t3_dev_ack", 8'hA0, 1'b0);
    chk("t3_busy_on", {31'd0, busy}, 32'd1);
    i2c_stop();
    #(Q);
    chk("t3_busy_off", {31'd0, busy}, 32'd0);

    // 4: page write across the 16-bit wrap
    wr_q.push_back(mk_wr(16'hFFFF, 8'h11, 2));
    wr_q.push_back(mk_wr(16'h0000, 8'h22, 2));
    i2c_start();
    write_byte("t4_dev_ack", 8'hA0, 1'b0);
    write_byte("t4_hi_ack", 8'hFF, 1'b0);
    write_byte("t4_lo_ack", 8'hFF, 1'b0);
    write_byte("t4_d0_ack", 8'h11, 1'b0);
    write_byte("t4_d1_ack", 8'h22, 1'b0);
    i2c_stop();
    #(Q);
    chk("t4_addr_wrap", {16'd0, addrBank, addrBlock, addrRow}, 32'h0001);

    // 5: sequential read of three bytes from 1234
    rd_q.push_back(16'h1234);
    rd_q.push_back(16'h1235);
    rd_q.push_back(16'h1236);
    i2c_start();
    write_byte("t5_dev_ack", 8'hA0, 1'b0);
    write_byte("t5_hi_ack", 8'h12, 1'b0);
    write_byte("t5_lo_ack", 8'h34, 1'b0);
    i2c_start();
    write_byte("t5_devr_ack", 8'hA1, 1'b0);
    read_byte("t5_data0", 8'hA1, 1'b0);
    read_byte("t5_data1", 8'hB2, 1'b0);
    read_byte("t5_data2", 8'hC3, 1'b1);
    i2c_stop();
    #(Q);
    chk("t5_addr_next", {16'd0, addrBank, addrBlock, addrRow}, 32'h1237);

    // 6a: STOP in the middle of a data byte
    i2c_start();
    write_byte("t6_dev_ack", 8'hA0, 1'b0);
    write_byte("t6_hi_ack", 8'h40, 1'b0);
    write_byte("t6_lo_ack", 8'h00, 1'b0);
    for (int i = 7; i >= 4; i--) write_bit(1'b1);
    i2c_stop();
    #(Q);
    chk("t6_stop_busy", {31'd0, busy}, 32'd0);
    chk("t6_stop_sdaoe", {31'd0, sdaOe}, 32'd0);
    chk("t6_stop_wrn", {31'd0, memWriteN}, 32'd1);

    // 6b: reset while the write strobe is low
    wr_q.push_back(mk_wr(16'h4100, 8'h77, 0));
    d77 = 8'h77;
    i2c_start();
    write_byte("t6_dev_ack2", 8'hA0, 1'b0);
    write_byte("t6_hi_ack2", 8'h41, 1'b0);
    write_byte("t6_lo_ack2", 8'h00, 1'b0);
    for (int i = 7; i >= 1; i--) write_bit(d77[i]);
    sda_m = d77[0]; #(Q); scl = 1'b1;
    n = 0;
    while (memWriteN !== 1'b0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_strobe_seen", {31'd0, memWriteN}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_wrn", {31'd0, memWriteN}, 32'd1);
    chk("t6_rst_sdaoe", {31'd0, sdaOe}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_addr", {16'd0, addrBank, addrBlock, addrRow}, 32'd0);
    sda_m = 1'b1; scl = 1'b1;
    repeat (4) @(posedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("wr_q_empty", wr_q.size(), 32'd0);
    chk("rd_q_empty", rd_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
